// File: rtl/alu_result_packer_if.sv
// Bundle of ALU-result input, UART TX byte handshake and status signals for alu_result_packer.
// The master side drives results and TX_READY; the slave side is the packer.
interface alu_result_packer_if #(
    parameter int unsigned IN_WIDTH = 16
);
    logic [IN_WIDTH-1:0] ALU_OUT;
    logic                OUT_VALID;
    logic                TX_READY;
    logic                OVF_CLR;
    logic [7:0]          TX_DATA;
    logic                TX_VALID;
    logic                OVF;
    logic                BUSY;

    modport master (
        output ALU_OUT, OUT_VALID, TX_READY, OVF_CLR,
        input  TX_DATA, TX_VALID, OVF, BUSY
    );

    modport slave (
        input  ALU_OUT, OUT_VALID, TX_READY, OVF_CLR,
        output TX_DATA, TX_VALID, OVF, BUSY
    );
endinterface

// File: rtl/alu_result_packer.sv
// Buffers ALU results in a small FIFO and streams each one LSB-first as bytes to a UART TX port.
// Optional ALU_PACKER_HDR_EN prefixes every frame with HDR_BYTE.
module alu_result_packer #(
    parameter int unsigned IN_WIDTH = 16,
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              RST,
    alu_result_packer_if.slave bus
);

    localparam int unsigned NBYTES = IN_WIDTH / 8;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef logic [NBYTES-1:0][7:0] word_t;

`ifdef ALU_PACKER_HDR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2} state_t;
    logic [7:0] unused_hdr_c;
    assign unused_hdr_c = HDR_BYTE;
`endif

    word_t             mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              pop_c, wr_c, drop_c;
    word_t             head_c;

    assign head_c = mem_q[rd_ptr_q];

    // A full FIFO still accepts a result when the head frees its slot on the same edge.
    assign wr_c   = bus.OUT_VALID && ((count_q != FULL) || pop_c);
    assign drop_c = bus.OUT_VALID && !wr_c;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        pop_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (count_q != '0) begin
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
`ifdef ALU_PACKER_HDR_EN
                    state_d    = HDR;
                    tx_data_d  = HDR_BYTE;
`else
                    state_d    = DATA;
                    tx_data_d  = head_c[0];
`endif
                end
            end
`ifdef ALU_PACKER_HDR_EN
            HDR: begin
                if (bus.TX_READY) begin
                    state_d   = DATA;
                    tx_data_d = head_c[0];
                end
            end
`endif
            DATA: begin
                if (bus.TX_READY) begin
                    if (idx_q == LAST_IDX) begin
                        pop_c      = 1'b1;
                        state_d    = IDLE;
                        idx_d      = '0;
                        tx_valid_d = 1'b0;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        tx_data_d = head_c[idx_q + IDX_W'(1)];
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q + CNT_W'(wr_c) - CNT_W'(pop_c);
        ovf_d   = drop_c ? 1'b1 : (bus.OVF_CLR ? 1'b0 : ovf_q);
        busy_d  = (count_d != '0) || (state_d != IDLE);
    end

    // Storage needs no reset: occupancy is tracked by count_q and the pointers.
    always_ff @(posedge clk) begin
        if (wr_c) mem_q[wr_ptr_q] <= bus.ALU_OUT;
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            if (wr_c)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    assign bus.TX_DATA  = tx_data_q;
    assign bus.TX_VALID = tx_valid_q;
    assign bus.OVF      = ovf_q;
    assign bus.BUSY     = busy_q;

endmodule
